// File: rtl/mem_reader_pkg.sv
// Shared definitions for the SRAM read-back controller: FSM encoding and the
// default geometry/pattern, also used by the write controller and debug display.
package mem_reader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      CAPT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int MR_ADDR_W   = 5;
   localparam int MR_DATA_W   = 8;
   localparam int MR_DEPTH    = 32;
   localparam int MR_PAT_BASE = 1;

endpackage

// File: rtl/mem_reader.sv
// SRAM read-back controller: scans every location, streams each word out and
// checks it against the PAT_BASE+address pattern, reporting count and first failure.
//
// state | meaning
// IDLE  | port released, results held, waiting for s
// ADDR  | MAR driven with CS/OE, read data latched into MDR at the edge
// CAPT  | MDR valid, compared against pattern, advance or finish
// DONE  | one-cycle done pulse, then back to IDLE
module mem_reader
   import mem_reader_pkg::*;
#(
   parameter int ADDR_W   = MR_ADDR_W,
   parameter int DATA_W   = MR_DATA_W,
   parameter int DEPTH    = MR_DEPTH,
   parameter int PAT_BASE = MR_PAT_BASE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] MAR,
   output logic              CS,
   output logic              OE,
   output logic              WE,
   output logic [DATA_W-1:0] MDR,
   output logic              data_valid,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              err_flag,
   output logic [1:0]        curstate
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] PAT       = DATA_W'(PAT_BASE);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

   state_t state_q, state_d;
   logic [DATA_W-1:0] exp_data;
   logic mismatch;

   assign exp_data = PAT + DATA_W'(MAR);
   assign mismatch = (MDR != exp_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      CS         = 1'b0;
      OE         = 1'b0;
      WE         = 1'b0;
      data_valid = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: if (s) state_d = ADDR;
         ADDR: begin
            CS      = 1'b1;
            OE      = 1'b1;
            state_d = CAPT;
         end
         CAPT: begin
            CS         = 1'b1;
            OE         = 1'b1;
            data_valid = 1'b1;
            state_d    = (MAR == LAST_ADDR) ? DONE : ADDR;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         MAR            <= '0;
         MDR            <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
         err_flag       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (s) begin
               MAR            <= '0;
               err_count      <= '0;
               err_flag       <= 1'b0;
               first_err_addr <= '0;
            end
            ADDR: MDR <= rd_data;
            CAPT: begin
               if (mismatch) begin
                  err_count <= err_count + CNT_ONE;
                  if (!err_flag) begin
                     first_err_addr <= MAR;
                     err_flag       <= 1'b1;
                  end
               end
               // MAR parks on the last address so it never wraps
               if (MAR != LAST_ADDR) MAR <= MAR + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign curstate = state_q;

endmodule

// File: tb/tb_mem_reader.sv
// Bench for mem_reader: SRAM array responder plus a pattern-checking reference
// model computed directly from memory contents.
module tb_mem_reader;

   localparam int AW    = 5;
   localparam int DW    = 8;
   localparam int DEPTH = 32;
   localparam int PAT   = 1;
   localparam int SCAN  = 2*DEPTH + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          s = 1'b0;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] MAR;
   logic          CS, OE, WE;
   logic [DW-1:0] MDR;
   logic          data_valid, done;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr;
   logic          err_flag;
   logic [1:0]    curstate;

   logic [DW-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] obs_words [$];
   int obs_done_cyc, obs_done_n, obs_ctl_bad;
   int exp_cnt, exp_first;
   bit exp_flag;

   always #5 clk = ~clk;

   assign rd_data = mem[MAR];

   mem_reader dut (
      .clk(clk), .reset(reset), .s(s), .rd_data(rd_data),
      .MAR(MAR), .CS(CS), .OE(OE), .WE(WE), .MDR(MDR),
      .data_valid(data_valid), .done(done), .err_count(err_count),
      .first_err_addr(first_err_addr), .err_flag(err_flag), .curstate(curstate)
   );

   task automatic model();
      exp_cnt = 0; exp_first = 0; exp_flag = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (mem[a] != DW'((PAT + a) % 256)) begin
            if (!exp_flag) begin
               exp_first = a;
               exp_flag  = 1;
            end
            exp_cnt++;
         end
      end
   endtask

   task automatic fill_clean();
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'((PAT + a) % 256);
   endtask

   // Drives one start pulse and records what the DUT does; cycle 0 is the start edge.
   task automatic run_scan(input bit mid_pulse, input int ncyc);
      bit exp_cs;
      obs_words.delete();
      obs_done_cyc = -1; obs_done_n = 0; obs_ctl_bad = 0;
      @(negedge clk) s = 1'b1;
      @(posedge clk); #1 s = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         exp_cs = (c >= 1 && c <= 2*DEPTH);
         if (data_valid) obs_words.push_back(MDR);
         if (done) begin
            obs_done_n++;
            if (obs_done_cyc < 0) obs_done_cyc = c;
         end
         if (WE !== 1'b0 || CS !== exp_cs || OE !== exp_cs) obs_ctl_bad++;
         if (mid_pulse && c == 11) s = 1'b1;
         if (mid_pulse && c == 12) s = 1'b0;
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({MAR, MDR, err_count, first_err_addr, err_flag, CS, OE, WE, data_valid, done, curstate} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got MAR=%0d MDR=%0h cnt=%0d first=%0d flag=%b CS=%b OE=%b WE=%b dv=%b done=%b st=%0d, want all 0",
                  MAR, MDR, err_count, first_err_addr, err_flag, CS, OE, WE, data_valid, done, curstate);
      end
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_pattern(input string name, input bit mid);
      model();
      run_scan(mid, SCAN + 5);
      n_checks++;
      if (obs_words.size() != DEPTH) begin
         n_fail++;
         $display("FAIL %s_nwords: got %0d want %0d", name, obs_words.size(), DEPTH);
      end
      for (int a = 0; a < DEPTH && a < obs_words.size(); a++) begin
         n_checks++;
         if (obs_words[a] !== mem[a]) begin
            n_fail++;
            $display("FAIL %s_word[%0d]: got %0h want %0h", name, a, obs_words[a], mem[a]);
         end
      end
      n_checks++;
      if (obs_done_n != 1 || obs_done_cyc != SCAN) begin
         n_fail++;
         $display("FAIL %s_done: got %0d pulses first at cycle %0d, want 1 at cycle %0d", name, obs_done_n, obs_done_cyc, SCAN);
      end
      n_checks++;
      if (obs_ctl_bad != 0) begin
         n_fail++;
         $display("FAIL %s_ctl: got %0d bad CS/OE/WE cycles, want 0", name, obs_ctl_bad);
      end
      n_checks++;
      if (err_count !== (AW+1)'(exp_cnt) || err_flag !== exp_flag || first_err_addr !== AW'(exp_first)) begin
         n_fail++;
         $display("FAIL %s_results: got cnt=%0d flag=%b first=%0d, want cnt=%0d flag=%b first=%0d",
                  name, err_count, err_flag, first_err_addr, exp_cnt, exp_flag, exp_first);
      end
      n_checks++;
      if (curstate !== 2'd0 || data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: got st=%0d dv=%b, want st=0 dv=0", name, curstate, data_valid);
      end
   endtask

   task automatic test_reset_mid_scan();
      int bad = 0;
      fill_clean();
      @(negedge clk) s = 1'b1;
      @(posedge clk); #1 s = 1'b0;
      for (int c = 1; c <= 26; c++) @(negedge clk);
      n_checks++;
      if (MAR !== AW'(12) || data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got MAR=%0d dv=%b, want MAR=12 dv=1", MAR, data_valid);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({MAR, MDR, err_count, first_err_addr, err_flag, CS, OE, WE, data_valid, done, curstate} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async: got MAR=%0d MDR=%0h cnt=%0d st=%0d CS=%b dv=%b done=%b, want all 0",
                  MAR, MDR, err_count, curstate, CS, data_valid, done);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || CS !== 1'b0 || WE !== 1'b0) bad++;
      end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done !== 1'b0 || CS !== 1'b0 || WE !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL rst_mid_quiet: got %0d cycles with done/CS/WE set, want 0", bad);
      end
      test_pattern("post_reset", 1'b0);
   endtask

   task automatic test_s_held();
      int dc [$];
      fill_clean();
      @(negedge clk) s = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 2*SCAN + 1; c++) begin
         @(negedge clk);
         if (done) dc.push_back(c);
         if (c == 2*SCAN + 1) s = 1'b0;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (dc.size() != 2 || dc[0] != SCAN || dc[1] != 2*SCAN + 1) begin
         n_fail++;
         $display("FAIL s_held_done: got %0d pulses (first %0d), want 2 at %0d and %0d",
                  dc.size(), (dc.size() > 0) ? dc[0] : -1, SCAN, 2*SCAN + 1);
      end
      n_checks++;
      if (curstate !== 2'd0 || err_count !== '0) begin
         n_fail++;
         $display("FAIL s_held_end: got st=%0d cnt=%0d, want st=0 cnt=0", curstate, err_count);
      end
   endtask

   initial begin
      fill_clean();
      test_reset();

      test_pattern("clean", 1'b0);

      mem[7] = 8'h55; mem[20] = 8'h00;
      test_pattern("two_errs", 1'b0);

      for (int a = 0; a < DEPTH; a++) mem[a] = 8'hFF;
      test_pattern("all_ff", 1'b0);

      for (int i = 0; i < 3; i++) begin
         fill_clean();
         for (int a = 0; a < DEPTH; a++)
            if ($urandom_range(3) == 0) mem[a] = DW'($urandom);
         test_pattern($sformatf("rand%0d", i), 1'b0);
      end

      fill_clean();
      mem[3] = 8'hA5;
      test_pattern("restart_ignored", 1'b1);

      test_reset_mid_scan();
      test_s_held();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
